// File: rtl/washer_plant_sense_if.sv
// Controller <-> plant-sensor signal bundle for washer_plant_sense.
// master = washer controller side, slave = plant sensor side.
interface washer_plant_sense_if;
    logic       tick;
    logic       door_sw;
    logic       door_lock;
    logic       motor_on;
    logic       fill_value_on;
    logic       drain_value_on;
    logic       door_close;
    logic       filled;
    logic       drained;
    logic       cycle_timeout;
    logic       spin_timeout;
    logic       fault;
    logic [7:0] level;

    modport master (
        output tick, door_sw, door_lock, motor_on, fill_value_on, drain_value_on,
        input  door_close, filled, drained, cycle_timeout, spin_timeout, fault, level
    );

    modport slave (
        input  tick, door_sw, door_lock, motor_on, fill_value_on, drain_value_on,
        output door_close, filled, drained, cycle_timeout, spin_timeout, fault, level
    );
endinterface

// File: rtl/washer_plant_sense.sv
// Washer plant model: tank level, wash/spin timers and debounced door switch.
// Optional sticky fault flag built only when WASHER_SENSE_FAULT_EN is defined.
module washer_plant_sense #(
    parameter int unsigned LEVEL_MAX  = 200,
    parameter int unsigned WASH_TICKS = 1000,
    parameter int unsigned SPIN_TICKS = 500,
    parameter int unsigned DEBOUNCE   = 16
) (
    input  logic clk,
    input  logic reset,
    washer_plant_sense_if.slave bus
);

    localparam logic [7:0]  LVL_MAX  = 8'(LEVEL_MAX);
    localparam logic [15:0] WASH_MAX = 16'(WASH_TICKS);
    localparam logic [15:0] SPIN_MAX = 16'(SPIN_TICKS);
    localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE - 1);

    logic [7:0]  level_q, level_d;
    logic        filled_q, filled_d;
    logic        drained_q, drained_d;
    logic [15:0] wash_q, wash_d;
    logic        cyc_to_q, cyc_to_d;
    logic [15:0] spin_q, spin_d;
    logic        spin_to_q, spin_to_d;
    logic        spin_cond;
    logic        sync1_q, sync2_q;
    logic [7:0]  deb_q, deb_d;
    logic        door_close_q, door_close_d;

    always_comb begin
        level_d = level_q;
        if (bus.tick) begin
            if (bus.fill_value_on && !bus.drain_value_on && level_q != LVL_MAX)
                level_d = level_q + 8'd1;
            else if (bus.drain_value_on && !bus.fill_value_on && level_q != '0)
                level_d = level_q - 8'd1;
        end
        filled_d  = (level_q == LVL_MAX);
        drained_d = (level_q == '0);

        wash_d = wash_q;
        if (!bus.motor_on)
            wash_d = '0;
        else if (bus.tick && wash_q != WASH_MAX)
            wash_d = wash_q + 16'd1;
        cyc_to_d = bus.motor_on && (wash_q == WASH_MAX);

        spin_cond = bus.door_lock && !bus.motor_on && !bus.fill_value_on &&
                    !bus.drain_value_on && (level_q == '0);
        spin_d = spin_q;
        if (!spin_cond)
            spin_d = '0;
        else if (bus.tick && spin_q != SPIN_MAX)
            spin_d = spin_q + 16'd1;
        spin_to_d = spin_cond && (spin_q == SPIN_MAX);

        // Counter tracks consecutive cycles of disagreement; the DEBOUNCE-th one commits.
        deb_d        = deb_q;
        door_close_d = door_close_q;
        if (sync2_q == door_close_q) begin
            deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
            door_close_d = sync2_q;
            deb_d        = '0;
        end else begin
            deb_d = deb_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q      <= '0;
            filled_q     <= 1'b0;
            drained_q    <= 1'b1;
            wash_q       <= '0;
            cyc_to_q     <= 1'b0;
            spin_q       <= '0;
            spin_to_q    <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_q        <= '0;
            door_close_q <= 1'b0;
        end else begin
            level_q      <= level_d;
            filled_q     <= filled_d;
            drained_q    <= drained_d;
            wash_q       <= wash_d;
            cyc_to_q     <= cyc_to_d;
            spin_q       <= spin_d;
            spin_to_q    <= spin_to_d;
            sync1_q      <= bus.door_sw;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            door_close_q <= door_close_d;
        end
    end

`ifdef WASHER_SENSE_FAULT_EN
    logic fault_q, fault_d;

    always_comb begin
        fault_d = fault_q;
        if ((bus.fill_value_on && bus.drain_value_on) ||
            (bus.motor_on && level_q == '0) ||
            (!bus.door_lock && bus.motor_on))
            fault_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fault_q <= 1'b0;
        else
            fault_q <= fault_d;
    end

    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    assign bus.level         = level_q;
    assign bus.filled        = filled_q;
    assign bus.drained       = drained_q;
    assign bus.cycle_timeout = cyc_to_q;
    assign bus.spin_timeout  = spin_to_q;
    assign bus.door_close    = door_close_q;

endmodule

// File: tb/tb_washer_plant_sense.sv
// Scoreboard bench for washer_plant_sense with small parameters
// (LEVEL_MAX=4, WASH_TICKS=3, SPIN_TICKS=2, DEBOUNCE=4).
module tb_washer_plant_sense;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    washer_plant_sense_if bus ();

    washer_plant_sense #(
        .LEVEL_MAX (4),
        .WASH_TICKS(3),
        .SPIN_TICKS(2),
        .DEBOUNCE  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

`ifdef WASHER_SENSE_FAULT_EN
    localparam logic FAULT_EXP = 1'b1;
`else
    localparam logic FAULT_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] level;
        logic       filled;
        logic       drained;
    } tank_t;

    tank_t tank_q[$];
    logic  bit_q[$];

    // {fill, drain, tick}
    localparam logic [2:0] HOLD_PAT [6] = '{3'b100, 3'b100, 3'b111, 3'b111, 3'b101, 3'b101};
    // {motor, tick}
    localparam logic [1:0] WASH_PAT [11] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10,
                                             2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    // {drain, lock, tick}
    localparam logic [2:0] SPIN_PAT [8] = '{3'b011, 3'b111, 3'b011, 3'b011, 3'b011, 3'b011,
                                            3'b001, 3'b010};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        bus.tick           = 1'b0;
        bus.door_sw        = 1'b0;
        bus.door_lock      = 1'b0;
        bus.motor_on       = 1'b0;
        bus.fill_value_on  = 1'b0;
        bus.drain_value_on = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        drive_idle();
        repeat (2) next_edge();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        logic [13:0] exp_v;
        exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        reset = 1'b0;
        drive_idle();
        repeat (2) next_edge();
        checks++;
        if ({bus.door_close, bus.filled, bus.drained, bus.cycle_timeout, bus.spin_timeout,
             bus.fault, bus.level} !== exp_v) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", {bus.door_close, bus.filled,
                     bus.drained, bus.cycle_timeout, bus.spin_timeout, bus.fault, bus.level}, exp_v);
        end
        reset = 1'b1;
        next_edge();
        checks++;
        if ({bus.door_close, bus.filled, bus.drained, bus.cycle_timeout, bus.spin_timeout,
             bus.fault, bus.level} !== exp_v) begin
            errors++;
            $display("FAIL reset_first_edge: got %b expected %b", {bus.door_close, bus.filled,
                     bus.drained, bus.cycle_timeout, bus.spin_timeout, bus.fault, bus.level}, exp_v);
        end
    endtask

    task automatic test_fill;
        logic [7:0] lvl;
        tank_t      e;
        lvl = 8'd0;
        bus.fill_value_on = 1'b1;
        bus.tick          = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            e.filled  = (lvl == 8'd4);
            e.drained = (lvl == 8'd0);
            if (lvl < 8'd4) lvl = lvl + 8'd1;
            e.level = lvl;
            tank_q.push_back(e);
            next_edge();
            e = tank_q.pop_front();
            checks++;
            if ({bus.level, bus.filled, bus.drained} !== e) begin
                errors++;
                $display("FAIL fill k=%0d: got lvl=%0d f=%b d=%b expected lvl=%0d f=%b d=%b", k,
                         bus.level, bus.filled, bus.drained, e.level, e.filled, e.drained);
            end
        end
    endtask

    task automatic test_drain;
        logic [7:0] lvl;
        tank_t      e;
        lvl = 8'd4;
        bus.fill_value_on  = 1'b0;
        bus.drain_value_on = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            bus.tick  = (k % 2 == 0);
            e.filled  = (lvl == 8'd4);
            e.drained = (lvl == 8'd0);
            if (bus.tick && lvl > 8'd0) lvl = lvl - 8'd1;
            e.level = lvl;
            tank_q.push_back(e);
            next_edge();
            e = tank_q.pop_front();
            checks++;
            if ({bus.level, bus.filled, bus.drained} !== e) begin
                errors++;
                $display("FAIL drain k=%0d: got lvl=%0d f=%b d=%b expected lvl=%0d f=%b d=%b", k,
                         bus.level, bus.filled, bus.drained, e.level, e.filled, e.drained);
            end
        end
        bus.drain_value_on = 1'b0;
        bus.tick           = 1'b0;
    endtask

    task automatic test_hold;
        logic [7:0] lvl;
        tank_t      e;
        lvl = 8'd0;
        for (int k = 0; k < 6; k++) begin
            {bus.fill_value_on, bus.drain_value_on, bus.tick} = HOLD_PAT[k];
            e.filled  = (lvl == 8'd4);
            e.drained = (lvl == 8'd0);
            if (bus.tick && bus.fill_value_on && !bus.drain_value_on && lvl < 8'd4)
                lvl = lvl + 8'd1;
            e.level = lvl;
            tank_q.push_back(e);
            next_edge();
            e = tank_q.pop_front();
            checks++;
            if ({bus.level, bus.filled, bus.drained} !== e) begin
                errors++;
                $display("FAIL hold k=%0d: got lvl=%0d f=%b d=%b expected lvl=%0d f=%b d=%b", k,
                         bus.level, bus.filled, bus.drained, e.level, e.filled, e.drained);
            end
        end
    endtask

    task automatic test_back_to_back;
        tank_t e;
        reset = 1'b0;
        drive_idle();
        #1;
        checks++;
        if ({bus.level, bus.filled, bus.drained} !== {8'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset_midfill: got lvl=%0d f=%b d=%b expected lvl=0 f=0 d=1",
                     bus.level, bus.filled, bus.drained);
        end
        next_edge();
        reset = 1'b1;
        bus.fill_value_on = 1'b1;
        bus.tick          = 1'b1;
        tank_q.push_back('{level: 8'd1, filled: 1'b0, drained: 1'b1});
        tank_q.push_back('{level: 8'd2, filled: 1'b0, drained: 1'b0});
        for (int k = 1; k <= 2; k++) begin
            next_edge();
            e = tank_q.pop_front();
            checks++;
            if ({bus.level, bus.filled, bus.drained} !== e) begin
                errors++;
                $display("FAIL refill k=%0d: got lvl=%0d f=%b d=%b expected lvl=%0d f=%b d=%b", k,
                         bus.level, bus.filled, bus.drained, e.level, e.filled, e.drained);
            end
        end
    endtask

    task automatic test_wash;
        int   cnt;
        logic e;
        do_reset();
        cnt = 0;
        bus.door_lock = 1'b1;
        for (int k = 0; k < 11; k++) begin
            {bus.motor_on, bus.tick} = WASH_PAT[k];
            bit_q.push_back(bus.motor_on && cnt == 3);
            if (!bus.motor_on) cnt = 0;
            else if (bus.tick && cnt < 3) cnt++;
            next_edge();
            e = bit_q.pop_front();
            checks++;
            if (bus.cycle_timeout !== e) begin
                errors++;
                $display("FAIL cycle_timeout k=%0d: got %b expected %b", k, bus.cycle_timeout, e);
            end
        end
        bus.motor_on = 1'b0;
    endtask

    task automatic test_spin;
        int   cnt;
        logic cond;
        logic e;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            {bus.drain_value_on, bus.door_lock, bus.tick} = SPIN_PAT[k];
            cond = bus.door_lock && !bus.drain_value_on;
            bit_q.push_back(cond && cnt == 2);
            if (!cond) cnt = 0;
            else if (bus.tick && cnt < 2) cnt++;
            next_edge();
            e = bit_q.pop_front();
            checks++;
            if (bus.spin_timeout !== e) begin
                errors++;
                $display("FAIL spin_timeout k=%0d: got %b expected %b", k, bus.spin_timeout, e);
            end
        end
        drive_idle();
    endtask

    task automatic test_door;
        logic e;
        bus.door_lock = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            bus.door_sw = (k <= 3) || (k >= 11 && k <= 20);
            bit_q.push_back(k >= 16 && k < 26);
            next_edge();
            e = bit_q.pop_front();
            checks++;
            if (bus.door_close !== e) begin
                errors++;
                $display("FAIL door_close k=%0d: got %b expected %b", k, bus.door_close, e);
            end
        end
        drive_idle();
    endtask

    task automatic test_fault;
        logic e;
        do_reset();
        bus.fill_value_on  = 1'b1;
        bus.drain_value_on = 1'b1;
        bit_q.push_back(FAULT_EXP);
        next_edge();
        drive_idle();
        repeat (3) bit_q.push_back(FAULT_EXP);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_edge();
            e = bit_q.pop_front();
            checks++;
            if (bus.fault !== e) begin
                errors++;
                $display("FAIL fault_sticky k=%0d: got %b expected %b", k, bus.fault, e);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_reset: got %b expected 0", bus.fault);
        end
        next_edge();
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive_idle();
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_hold();
        test_back_to_back();
        test_wash();
        test_spin();
        test_door();
        test_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/washer_plant_sense.md
WASHER_PLANT_SENSE -- requirements
Module: washer_plant_sense

Interface
REQ-001 Parameters: LEVEL_MAX, 200, tank level count at which filled asserts (1..255).
REQ-002 Parameters: WASH_TICKS, 1000, ticks of motor run before cycle_timeout asserts (1..65535).
REQ-003 Parameters: SPIN_TICKS, 500, ticks of spin condition before spin_timeout asserts (1..65535).
REQ-004 Parameters: DEBOUNCE, 16, consecutive clk cycles of stable door switch needed to update door_close (1..255).
REQ-005 Port: clk  in  1  clock; all state updates on its rising edge.
REQ-006 Port: reset  in  1  reset, asynchronous, active-low.
REQ-007 Port: tick  in  1  single-cycle timebase strobe; level and timers advance only when tick=1.
REQ-008 Port: door_sw  in  1  raw asynchronous door switch, 1 = closed.
REQ-009 Ports: door_lock, motor_on, fill_value_on, drain_value_on  in  1 each  actuator commands from the washer controller.
REQ-010 Ports: door_close, filled, drained, cycle_timeout, spin_timeout  out  1 each  registered sensor indications to the washer controller.
REQ-011 Port: level  out  8  current tank level count.
REQ-012 Port: fault  out  1  sticky fault flag (present only per REQ-030).

Function
REQ-013 Tank: on tick, fill_value_on=1 and drain_value_on=0 increments level, saturating at LEVEL_MAX.
REQ-014 Tank: on tick, drain_value_on=1 and fill_value_on=0 decrements level, saturating at 0.
REQ-015 Tank: both valves on, or neither, or tick=0 -> level holds.
REQ-016 filled is registered, equals (level==LEVEL_MAX) one cycle after level changes; drained likewise equals (level==0).
REQ-017 Wash timer: 16-bit counter increments on tick while motor_on=1, saturating at WASH_TICKS; clears to 0 in the cycle after motor_on=0 is sampled.
REQ-018 cycle_timeout is registered, =1 while wash counter==WASH_TICKS and motor_on=1; drops in the cycle after motor_on falls.
REQ-019 Spin condition = door_lock=1, motor_on=0, fill_value_on=0, drain_value_on=0, level==0.
REQ-020 Spin timer: 16-bit counter increments on tick while spin condition true, saturating at SPIN_TICKS; any cycle with condition false clears it.
REQ-021 spin_timeout is registered, =1 while spin counter==SPIN_TICKS and spin condition true.
REQ-022 Door: door_sw passes a 2-flop synchronizer; a counter counts clk cycles the synchronized value differs from door_close, resets to 0 when equal.
REQ-023 Door: when the counter reaches DEBOUNCE, door_close takes the synchronized value and the counter resets; glitches shorter than DEBOUNCE cycles never change door_close.
REQ-024 door_lock=1 while synchronized door_sw=0 does not alter door_close debouncing.
REQ-025 Timer counts and level never wrap; all saturations hold until the clearing condition.

Reset
REQ-026 reset=0 asynchronously forces: level=0, wash and spin counters=0, debounce counter=0, synchronizer flops=0.
REQ-027 Output values during and after reset until first update: door_close=0, filled=0, drained=1, cycle_timeout=0, spin_timeout=0, fault=0.
REQ-028 Reset deasserted mid-fill or mid-wash restarts from empty tank and zero timers; no state retained.
REQ-029 First state update occurs on the first rising clk edge with reset=1.

Configuration
REQ-030 Macro WASHER_SENSE_FAULT_EN defined: fault sets (sticky until reset) on any cycle where fill_value_on=1 and drain_value_on=1, or motor_on=1 with level==0, or door_lock=0 with motor_on=1.
REQ-031 Macro WASHER_SENSE_FAULT_EN undefined: fault port is driven constant 0 and no fault logic is built; all other behaviour identical.

Verification
REQ-032 LEVEL_MAX=4, fill_value_on=1, tick every cycle from reset -> level 1,2,3,4 then holds 4; filled=1 one cycle after level=4; drained falls one cycle after level=1.
REQ-033 level=4, drain_value_on=1 with tick every 2nd cycle -> level reaches 0 after 8 cycles, drained=1 next cycle, level stays 0 with drain still on.
REQ-034 WASH_TICKS=3, motor_on=1 five ticks -> cycle_timeout=1 after third tick, held; motor_on=0 -> cycle_timeout=0 next cycle, counter=0.
REQ-035 SPIN_TICKS=2, spin condition with drain pulse mid-count -> counter clears, spin_timeout only after 2 further uninterrupted ticks.
REQ-036 DEBOUNCE=4, door_sw 0->1 glitch for 3 cycles then stable high -> door_close stays 0 through glitch, rises 2+4 cycles after stable high.
REQ-037 Macro defined, fill and drain both on one cycle -> fault=1 next cycle, held until reset=0; macro undefined, same stimulus -> fault=0.
